// File: rtl/pwm_duty_ramp_if.sv
// Button inputs and duty-command outputs of the PWM duty ramp stage.
// The master side (button board / bench) drives the buttons and watches the duty outputs.
interface pwm_duty_ramp_if;
  logic        BTN_UP;
  logic        BTN_DN;
  logic [14:0] PWM;
  logic [14:0] TARGET;
  logic        BUSY;
  logic        TICK;

  modport master (
    output BTN_UP, BTN_DN,
    input  PWM, TARGET, BUSY, TICK
  );

  modport slave (
    input  BTN_UP, BTN_DN,
    output PWM, TARGET, BUSY, TICK
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty command for the PWM generator: debounced up/down buttons set a clamped target,
// and the compare value slews toward it by at most RAMP_STEP once per PWM period.
module pwm_duty_ramp #(
  parameter int PERIOD    = 25000,
  parameter int STEP      = 2500,
  parameter int RAMP_STEP = 250,
  parameter int DEBOUNCE  = 250000,
  parameter int INIT      = 0,
  // Duty ceiling; tracks PERIOD unless the tick rate is shortened independently.
  parameter int MAX_DUTY  = PERIOD
) (
  input  logic            CLK,
  input  logic            RST_N,
  pwm_duty_ramp_if.slave  bus
);

  localparam int NBTN = 2;
  localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [15:0]   STEP_W  = 16'(STEP);
  localparam logic [15:0]   RAMP_W  = 16'(RAMP_STEP);
  localparam logic [15:0]   MAX_W   = 16'(MAX_DUTY);
  localparam logic [14:0]   INIT_W  = 15'(INIT);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PERIOD - 1);

  // Lane 0 = up, lane 1 = down.
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] press;

  assign raw = {bus.BTN_DN, bus.BTN_UP};

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic          s1, s2, lvl, lvl_d, pulse;
    logic [DW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        lvl_d <= lvl;
        pulse <= lvl & ~lvl_d;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign press[i] = pulse;
  end

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          tick, busy;
  logic [14:0]   tgt, tgt_nxt, pwm, pwm_nxt;
  logic [15:0]   tgt_w, pwm_w, up_sum;
  logic [14:0]   dn_diff, rise, fall;

  assign pcnt_nxt = (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
  assign tgt_w    = {1'b0, tgt};
  assign pwm_w    = {1'b0, pwm};
  assign up_sum   = tgt_w + STEP_W;
  assign dn_diff  = 15'(tgt_w - STEP_W);
  assign rise     = 15'(pwm_w + RAMP_W);
  assign fall     = 15'(pwm_w - RAMP_W);

  // Opposing presses in the same cycle cancel.
  always_comb begin
    tgt_nxt = tgt;
    if (press[0] && !press[1])
      tgt_nxt = (up_sum > MAX_W) ? MAX_W[14:0] : up_sum[14:0];
    else if (press[1] && !press[0])
      tgt_nxt = (tgt_w >= STEP_W) ? dn_diff : '0;
  end

  // Ramp compares against the registered target, so a same-cycle target change waits a period.
  always_comb begin
    pwm_nxt = pwm;
    if (tick) begin
      if (pwm_w < tgt_w)
        pwm_nxt = ((tgt_w - pwm_w) > RAMP_W) ? rise : tgt;
      else if (pwm_w > tgt_w)
        pwm_nxt = ((pwm_w - tgt_w) > RAMP_W) ? fall : tgt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt <= '0;
      tick <= 1'b0;
      tgt  <= INIT_W;
      pwm  <= INIT_W;
      busy <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      tick <= (pcnt_nxt == P_LAST);
      tgt  <= tgt_nxt;
      pwm  <= pwm_nxt;
      busy <= (pwm_nxt != tgt_nxt);
    end
  end

  assign bus.PWM    = pwm;
  assign bus.TARGET = tgt;
  assign bus.BUSY   = busy;
  assign bus.TICK   = tick;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a short period and debounce window.
module tb_pwm_duty_ramp;
  logic CLK = 1'b0;
  logic RST_N;
  int   total = 0;
  int   bad   = 0;

  pwm_duty_ramp_if bus();

  pwm_duty_ramp #(
    .PERIOD(10), .STEP(2500), .RAMP_STEP(1000), .DEBOUNCE(4), .INIT(0), .MAX_DUTY(25000)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!bus.TICK && n < 25) begin
      step();
      n++;
    end
    if (!bus.TICK) chk("tick_timeout", 0, 1);
  endtask

  task automatic ramp_chk(input string tag, input int pre, input int post, input logic busy);
    wait_tick();
    chk({tag, "_pre"}, bus.PWM, pre);
    step();
    chk({tag, "_post"}, bus.PWM, post);
    chk({tag, "_busy"}, bus.BUSY, busy);
  endtask

  task automatic press_hold(input logic up, input logic dn);
    bus.BTN_UP = up;
    bus.BTN_DN = dn;
    step(8);
  endtask

  task automatic release_btns();
    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    step(10);
  endtask

  initial begin
    int cyc;
    int n;
    int e;

    RST_N      = 1'b0;
    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    step(3);
    chk("rst_pwm", bus.PWM, 0);
    chk("rst_target", bus.TARGET, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_tick", bus.TICK, 0);

    // Tick timing from release: first tick in cycle 10, then every 10.
    RST_N = 1'b1;
    cyc = 1;
    while (!bus.TICK && cyc < 30) begin
      step();
      cyc++;
    end
    chk("tick_first_cycle", cyc, 10);
    chk("post_rst_target", bus.TARGET, 0);
    chk("post_rst_busy", bus.BUSY, 0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!bus.TICK && n < 30);
      chk("tick_interval", n, 10);
    end

    // Bounce rejection.
    for (int k = 0; k < 3; k++) begin
      bus.BTN_UP = 1'b1;
      step(2);
      bus.BTN_UP = 1'b0;
      step(3);
    end
    step(10);
    chk("bounce_target", bus.TARGET, 0);

    bus.BTN_UP = 1'b1;
    step(7);
    chk("latency_minus1", bus.TARGET, 0);
    step(1);
    chk("latency_hit", bus.TARGET, 2500);
    chk("busy_after_up", bus.BUSY, 1);

    // Ramp up while the button stays held.
    ramp_chk("ru1", 0, 1000, 1'b1);
    ramp_chk("ru2", 1000, 2000, 1'b1);
    ramp_chk("ru3", 2000, 2500, 1'b0);
    chk("hold_no_repeat", bus.TARGET, 2500);
    release_btns();
    chk("release_no_change", bus.TARGET, 2500);

    // Both buttons at once cancel.
    press_hold(1'b1, 1'b1);
    chk("both_target", bus.TARGET, 2500);
    release_btns();
    chk("both_after_rel", bus.TARGET, 2500);

    // DN press landing on a tick: step uses the old target.
    wait_tick();
    step(3);
    bus.BTN_DN = 1'b1;
    step(7);
    chk("coinc_tick", bus.TICK, 1);
    chk("coinc_tgt_pre", bus.TARGET, 2500);
    step(1);
    chk("coinc_tgt_post", bus.TARGET, 0);
    chk("coinc_pwm_held", bus.PWM, 2500);
    chk("coinc_busy", bus.BUSY, 1);
    ramp_chk("rd1", 2500, 1500, 1'b1);
    ramp_chk("rd2", 1500, 500, 1'b1);
    ramp_chk("rd3", 500, 0, 1'b0);
    release_btns();

    press_hold(1'b0, 1'b1);
    chk("dn_floor", bus.TARGET, 0);
    release_btns();
    chk("dn_floor_pwm", bus.PWM, 0);

    // Async reset mid-ramp.
    for (int k = 0; k < 4; k++) begin
      press_hold(1'b1, 1'b0);
      release_btns();
    end
    chk("four_up_target", bus.TARGET, 10000);
    n = 0;
    while (bus.PWM < 3000 && n < 200) begin
      step();
      n++;
    end
    chk("mid_ramp_busy", bus.BUSY, 1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_pwm", bus.PWM, 0);
    chk("async_target", bus.TARGET, 0);
    chk("async_busy", bus.BUSY, 0);
    chk("async_tick", bus.TICK, 0);
    step(2);
    RST_N = 1'b1;
    step(1);
    chk("async_release_target", bus.TARGET, 0);

    // Clamp at the duty ceiling.
    for (int k = 0; k < 11; k++) begin
      press_hold(1'b1, 1'b0);
      e = (k + 1) * 2500;
      if (e > 25000) e = 25000;
      chk($sformatf("clamp_%0d", k), bus.TARGET, e);
      release_btns();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
